// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source skid FIFOs drained round-robin onto a
// registered CDB broadcast port, with almost-full backpressure and sticky overflow.
module cdb_arbiter #(
    parameter int unsigned      NUM_SRC     = 3,
    parameter int unsigned      TAG_W       = 5,
    parameter int unsigned      DATA_W      = 32,
    parameter int unsigned      FIFO_DEPTH  = 4,
    parameter logic [TAG_W-1:0] TAG_INVALID = {TAG_W{1'b1}}
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    output logic [NUM_SRC-1:0]          src_full,
    output logic                        cdb_valid,
    output logic [TAG_W-1:0]            cdb_tag,
    output logic [DATA_W-1:0]           cdb_data,
    output logic [$clog2(NUM_SRC)-1:0]  cdb_src,
    output logic                        overflow
);

    localparam int unsigned SRC_W = $clog2(NUM_SRC);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [TAG_W-1:0]  mem_tag_q  [NUM_SRC][FIFO_DEPTH];
    logic [TAG_W-1:0]  mem_tag_d  [NUM_SRC][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_q [NUM_SRC][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_d [NUM_SRC][FIFO_DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q [NUM_SRC];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_SRC];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_SRC];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_SRC];
    logic [CNT_W-1:0]  cnt_q    [NUM_SRC];
    logic [CNT_W-1:0]  cnt_d    [NUM_SRC];

    logic [NUM_SRC-1:0] full_q, full_d;
    logic [NUM_SRC-1:0] push, pop, accept, not_empty;

    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]  grant_idx;
    logic              grant_vld;

    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;
    logic              ovf_q, ovf_d;

    // A source pushes whenever its tag slice carries a real tag.
    always_comb begin
        push      = '0;
        not_empty = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            push[i]      = (src_tag[i*TAG_W +: TAG_W] != TAG_INVALID);
            not_empty[i] = (cnt_q[i] != '0);
        end
    end

    // Round-robin scan starting one past the last winner; uses registered state only.
    always_comb begin
        int unsigned      scan;
        logic [SRC_W-1:0] cand;
        scan      = 0;
        cand      = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            scan = (32'(rr_ptr_q) + k) % NUM_SRC;
            cand = SRC_W'(scan);
            if (!grant_vld && not_empty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        mem_tag_d   = mem_tag_q;
        mem_data_d  = mem_data_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        full_d      = '0;
        ovf_d       = ovf_q;
        rr_ptr_d    = rr_ptr_q;
        pop         = '0;
        accept      = '0;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = TAG_INVALID;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;

        if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                rd_ptr_d[i] = '0;
                wr_ptr_d[i] = '0;
                cnt_d[i]    = '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                pop[i]    = grant_vld && (grant_idx == SRC_W'(i));
                // A full FIFO still accepts when its head leaves on the same edge.
                accept[i] = push[i] && ((cnt_q[i] != CNT_W'(FIFO_DEPTH)) || pop[i]);
                if (push[i] && !accept[i]) begin
                    ovf_d = 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
                end
                if (accept[i]) begin
                    mem_tag_d[i][wr_ptr_q[i]]  = src_tag[i*TAG_W +: TAG_W];
                    mem_data_d[i][wr_ptr_q[i]] = src_data[i*DATA_W +: DATA_W];
                    wr_ptr_d[i]                = wr_ptr_q[i] + PTR_W'(1);
                end
                if (accept[i] && !pop[i]) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end else if (pop[i] && !accept[i]) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
                full_d[i] = (cnt_d[i] >= CNT_W'(FIFO_DEPTH - 1));
            end

            if (grant_vld) begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = mem_tag_q[grant_idx][rd_ptr_q[grant_idx]];
                cdb_data_d  = mem_data_q[grant_idx][rd_ptr_q[grant_idx]];
                cdb_src_d   = grant_idx;
                rr_ptr_d    = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q    <= '{default: '0};
            wr_ptr_q    <= '{default: '0};
            cnt_q       <= '{default: '0};
            full_q      <= '0;
            ovf_q       <= 1'b0;
            rr_ptr_q    <= SRC_W'(NUM_SRC - 1);
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= TAG_INVALID;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    // Storage is qualified by the counters, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_tag_q  <= mem_tag_d;
        mem_data_q <= mem_data_d;
    end

    assign src_full  = full_q;
    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;
    assign overflow  = ovf_q;

endmodule
